csr_regfile: RTL and testbench

- Control/status register file: the execution end of the CSR instruction path.
- Accepts reads and masked writes from the WB-stage CSR ops (csrrd/csrwr/csrxchg), plus exception entry and ertn return from the pipeline.
- Holds the LoongArch-32 base CSR subset and a countdown timer.
- Produces the exception entry address, the return address, and the interrupt request back to the pipeline.

---
 rtl/csr_regfile.sv | 165 ++++++++++++++++
 tb/tb_csr_regfile.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// csr_regfile: LoongArch-32 base CSR subset with exception/ertn state and countdown timer.
// Define CSR_TIMER_EN to build TID/TCFG/TVAL/TICLR and the timer; otherwise 0x40-0x44 are unmapped.
module csr_regfile #(
    parameter logic [31:0] TID_INIT    = 32'h0000_0000,
    parameter logic [31:0] EENTRY_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic        ertn_flush,
    output logic [31:0] ex_entry,
    output logic [31:0] era_out,
    output logic        has_int
);
    localparam logic [13:0] CRMD   = 14'h0;
    localparam logic [13:0] PRMD   = 14'h1;
    localparam logic [13:0] ECFG   = 14'h4;
    localparam logic [13:0] ESTAT  = 14'h5;
    localparam logic [13:0] ERA    = 14'h6;
    localparam logic [13:0] EENTRY = 14'hC;
    localparam logic [13:0] TID    = 14'h40;
    localparam logic [13:0] TCFG   = 14'h41;
    localparam logic [13:0] TVAL   = 14'h42;
    localparam logic [13:0] TICLR  = 14'h44;

    logic [3:0]       crmd_q, crmd_d;
    logic [2:0]       prmd_q, prmd_d;
    logic [12:0]      ecfg_q, ecfg_d;
    logic [1:0]       sw_is_q, sw_is_d;
    logic [5:0]       ecode_q, ecode_d;
    logic [8:0]       esub_q, esub_d;
    logic [31:0]      era_q, era_d;
    logic [25:0]      eentry_q, eentry_d;
    logic [3:0][31:0] save_q, save_d;
    logic             timer_is;
    logic [12:0]      is_all;
    logic [31:0]      wnew;
    logic             unused;

    assign unused = csr_re;
    assign is_all = {1'b0, timer_is, 9'b0, sw_is_q};
    assign wnew = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);
    assign has_int = crmd_q[2] & |(is_all & ecfg_q);
    assign ex_entry = {eentry_q, 6'b0};
    assign era_out = era_q;

`ifdef CSR_TIMER_EN
    logic [31:0] tid_q, tid_d, tcfg_q, tcfg_d, tval_q, tval_d;
    logic        timer_is_q, timer_is_d, load, fire, ticlr;

    assign timer_is = timer_is_q;
    assign load = csr_we && csr_num == TCFG && wnew[0];
    assign fire = !load && tcfg_q[0] && tval_q == 32'd1;
    assign ticlr = csr_we && csr_num == TICLR && csr_wmask[0] && csr_wvalue[0];

    always_comb begin
        tid_d = (csr_we && csr_num == TID) ? wnew : tid_q;
        tcfg_d = (csr_we && csr_num == TCFG) ? wnew : tcfg_q;
        tval_d = tval_q;
        if (load)
            tval_d = {wnew[31:2], 2'b00};
        else if (tcfg_q[0] && tval_q != 32'd0)
            tval_d = fire ? (tcfg_q[1] ? {tcfg_q[31:2], 2'b00} : 32'd0) : tval_q - 32'd1;
        // A timer expiry in the same cycle as a TICLR write leaves the interrupt set
        timer_is_d = fire ? 1'b1 : (ticlr ? 1'b0 : timer_is_q);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tid_q      <= TID_INIT;
            tcfg_q     <= '0;
            tval_q     <= '0;
            timer_is_q <= 1'b0;
        end else begin
            tid_q      <= tid_d;
            tcfg_q     <= tcfg_d;
            tval_q     <= tval_d;
            timer_is_q <= timer_is_d;
        end
    end
`else
    assign timer_is = 1'b0;
`endif

    always_comb begin
        csr_rvalue = '0;
        case (csr_num)
            CRMD:   csr_rvalue = {28'b0, crmd_q};
            PRMD:   csr_rvalue = {29'b0, prmd_q};
            ECFG:   csr_rvalue = {19'b0, ecfg_q};
            ESTAT:  csr_rvalue = {1'b0, esub_q, ecode_q, 3'b0, is_all};
            ERA:    csr_rvalue = era_q;
            EENTRY: csr_rvalue = {eentry_q, 6'b0};
            14'h30, 14'h31, 14'h32, 14'h33: csr_rvalue = save_q[csr_num[1:0]];
`ifdef CSR_TIMER_EN
            TID:    csr_rvalue = tid_q;
            TCFG:   csr_rvalue = tcfg_q;
            TVAL:   csr_rvalue = tval_q;
`endif
            default: csr_rvalue = '0;
        endcase
    end

    // Exception/ertn own CRMD, PRMD, ERA and ESTAT in their cycle; CSR writes to them are dropped
    always_comb begin
        crmd_d = crmd_q;
        prmd_d = prmd_q;
        sw_is_d = sw_is_q;
        ecode_d = ecode_q;
        esub_d = esub_q;
        era_d = era_q;
        ecfg_d = (csr_we && csr_num == ECFG) ? wnew[12:0] : ecfg_q;
        eentry_d = (csr_we && csr_num == EENTRY) ? wnew[31:6] : eentry_q;
        save_d = save_q;
        if (csr_we && csr_num[13:2] == 12'hC)
            save_d[csr_num[1:0]] = wnew;
        if (wb_ex) begin
            prmd_d = crmd_q[2:0];
            crmd_d[2:0] = 3'b0;
            era_d = wb_pc;
            ecode_d = wb_ecode;
            esub_d = wb_esubcode;
        end else if (ertn_flush) begin
            crmd_d[2:0] = prmd_q;
        end else if (csr_we) begin
            crmd_d = (csr_num == CRMD) ? wnew[3:0] : crmd_q;
            prmd_d = (csr_num == PRMD) ? wnew[2:0] : prmd_q;
            sw_is_d = (csr_num == ESTAT) ? wnew[1:0] : sw_is_q;
            era_d = (csr_num == ERA) ? wnew : era_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_q   <= 4'h8;
            prmd_q   <= '0;
            ecfg_q   <= '0;
            sw_is_q  <= '0;
            ecode_q  <= '0;
            esub_q   <= '0;
            era_q    <= '0;
            eentry_q <= EENTRY_INIT[31:6];
            save_q   <= '0;
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            ecfg_q   <= ecfg_d;
            sw_is_q  <= sw_is_d;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            era_q    <= era_d;
            eentry_q <= eentry_d;
            save_q   <= save_d;
        end
    end
endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: vector table, randomized run against a CSR-level model, and exception/timer sequences.
module tb_csr_regfile;
    logic        clk = 0, resetn = 0, csr_re = 0, csr_we = 0, wb_ex = 0, ertn_flush = 0, has_int;
    logic [13:0] csr_num = 0;
    logic [31:0] csr_wmask = 0, csr_wvalue = 0, wb_pc = 0, csr_rvalue, ex_entry, era_out;
    logic [5:0]  wb_ecode = 0;
    logic [8:0]  wb_esubcode = 0;
    int n_chk = 0, n_fail = 0;
    logic [31:0] mdl [64];
    logic [31:0] nxt [64];

    typedef struct {
        logic [13:0] num;
        logic [31:0] mask;
        logic [31:0] value;
        logic [31:0] exp_old;
        logic [31:0] exp_new;
    } vec_t;
    vec_t vecs [17];
    int nums [12] = '{0, 1, 4, 5, 6, 7, 'hC, 'h30, 'h31, 'h32, 'h33, 2};

    always #5 clk = ~clk;

    csr_regfile dut (
        .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .ertn_flush(ertn_flush),
        .ex_entry(ex_entry), .era_out(era_out), .has_int(has_int)
    );

    function automatic logic [31:0] wmsk(int n);
        case (n)
            0: return 32'hF;
            1: return 32'h7;
            4: return 32'h1FFF;
            5: return 32'h3;
            6, 'h30, 'h31, 'h32, 'h33: return 32'hFFFF_FFFF;
            'hC: return 32'hFFFF_FFC0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(logic [13:0] n, logic [31:0] exp, string nm);
        csr_num = n;
        #1;
        chk(nm, csr_rvalue, exp);
    endtask

    task automatic wr(logic [13:0] n, logic [31:0] m, logic [31:0] v);
        csr_num = n;
        csr_wmask = m;
        csr_wvalue = v;
        csr_we = 1;
        tick();
        csr_we = 0;
    endtask

    task automatic do_reset;
        resetn = 0;
        #12;
        resetn = 1;
        tick();
    endtask

    initial begin
        vecs = '{
            '{14'h31, 32'h0000_FF00, 32'hFFFF_FFFF, 32'h0, 32'h0000_FF00},
            '{14'h31, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_FF00, 32'h1234_5678},
            '{14'h00, 32'h7, 32'h7, 32'h8, 32'hF},
            '{14'h00, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hF, 32'h0},
            '{14'h00, 32'hFFFF_FFFF, 32'h8, 32'h0, 32'h8},
            '{14'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h7},
            '{14'h01, 32'hFFFF_FFFF, 32'h0, 32'h7, 32'h0},
            '{14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1FFF},
            '{14'h04, 32'hFFFF_FFFF, 32'h0, 32'h1FFF, 32'h0},
            '{14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h3},
            '{14'h05, 32'hFFFF_FFFF, 32'h0, 32'h3, 32'h0},
            '{14'h0C, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 32'h1234_5640},
            '{14'h06, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0, 32'hF0F0_F0F0},
            '{14'h06, 32'hFFFF_FFFF, 32'h0, 32'hF0F0_F0F0, 32'h0},
            '{14'h07, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0},
            '{14'h0C, 32'hFFFF_FFFF, 32'h0, 32'h1234_5640, 32'h0},
            '{14'h31, 32'hFFFF_FFFF, 32'h0, 32'h1234_5678, 32'h0}
        };
        do_reset();
        rd(14'h0, 32'h8, "reset_crmd");
        rd(14'h5, 32'h0, "reset_estat");
        chk("reset_has_int", 32'(has_int), 32'h0);
        chk("reset_ex_entry", ex_entry, 32'h0);
        chk("reset_era_out", era_out, 32'h0);

        foreach (vecs[i]) begin
            rd(vecs[i].num, vecs[i].exp_old, $sformatf("vec%0d_old", i));
            wr(vecs[i].num, vecs[i].mask, vecs[i].value);
            rd(vecs[i].num, vecs[i].exp_new, $sformatf("vec%0d_new", i));
        end

        foreach (mdl[i]) mdl[i] = 32'h0;
        mdl[0] = 32'h8;
        for (int it = 0; it < 300; it++) begin
            int n;
            logic [31:0] m;
            n = nums[$urandom_range(0, 11)];
            csr_num = 14'(n);
            csr_we = 1'($urandom_range(0, 1));
            csr_wmask = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom();
            csr_wvalue = $urandom();
            wb_ex = ($urandom_range(0, 7) == 0);
            ertn_flush = ($urandom_range(0, 7) == 0);
            wb_pc = $urandom();
            wb_ecode = 6'($urandom());
            wb_esubcode = 9'($urandom());
            #1;
            chk("rand_read", csr_rvalue, mdl[n]);
            chk("rand_has_int", 32'(has_int), 32'(mdl[0][2] & |(mdl[5][12:0] & mdl[4][12:0])));
            chk("rand_ex_entry", ex_entry, mdl[12]);
            chk("rand_era_out", era_out, mdl[6]);
            nxt = mdl;
            if (csr_we && !((wb_ex || ertn_flush) && n inside {0, 1, 5, 6})) begin
                m = csr_wmask & wmsk(n);
                nxt[n] = (mdl[n] & ~m) | (csr_wvalue & m);
            end
            if (wb_ex) begin
                nxt[1] = mdl[0] & 32'h7;
                nxt[0] = mdl[0] & ~32'h7;
                nxt[6] = wb_pc;
                nxt[5] = (mdl[5] & 32'hFFFF) | (32'(wb_ecode) << 16) | (32'(wb_esubcode) << 22);
            end else if (ertn_flush) begin
                nxt[0] = (mdl[0] & ~32'h7) | (mdl[1] & 32'h7);
            end
            tick();
            mdl = nxt;
        end
        csr_we = 0;
        wb_ex = 0;
        ertn_flush = 0;

        do_reset();
        wr(14'h0, 32'h7, 32'h7);
        rd(14'h0, 32'hF, "crmd_pre_ex");
        wb_ex = 1;
        wb_ecode = 6'h0B;
        wb_esubcode = 0;
        wb_pc = 32'h1C00_0100;
        tick();
        wb_ex = 0;
        rd(14'h0, 32'h8, "ex_crmd");
        rd(14'h1, 32'h7, "ex_prmd");
        rd(14'h6, 32'h1C00_0100, "ex_era");
        rd(14'h5, 32'h000B_0000, "ex_estat");
        chk("ex_era_out", era_out, 32'h1C00_0100);
        ertn_flush = 1;
        tick();
        ertn_flush = 0;
        rd(14'h0, 32'hF, "ertn_crmd");

        wb_ex = 1;
        wb_pc = 32'h2000_0040;
        wr(14'h6, 32'hFFFF_FFFF, 32'h1234);
        rd(14'h6, 32'h2000_0040, "prio_era");
        wb_pc = 32'h2000_0080;
        wr(14'h30, 32'hFFFF_FFFF, 32'hCAFE);
        wb_ex = 0;
        rd(14'h30, 32'hCAFE, "prio_save0");
        rd(14'h1, 32'h0, "prio_prmd");
        ertn_flush = 1;
        wr(14'h0, 32'hFFFF_FFFF, 32'hF);
        ertn_flush = 0;
        rd(14'h0, 32'h8, "prio_ertn_crmd");

`ifdef CSR_TIMER_EN
        do_reset();
        wr(14'h41, 32'hFFFF_FFFF, 32'hB);
        rd(14'h42, 32'h8, "per_load");
        repeat (7) tick();
        rd(14'h42, 32'h1, "per_tval1");
        tick();
        rd(14'h42, 32'h8, "per_reload");
        rd(14'h5, 32'h800, "per_is11");
        wr(14'h4, 32'hFFFF_FFFF, 32'h800);
        wr(14'h0, 32'h4, 32'h4);
        chk("per_has_int", 32'(has_int), 32'h1);
        wr(14'h44, 32'h1, 32'h1);
        rd(14'h5, 32'h0, "per_ticlr");
        chk("per_has_int_clr", 32'(has_int), 32'h0);
        rd(14'h41, 32'hB, "per_tcfg");

        do_reset();
        wr(14'h41, 32'hFFFF_FFFF, 32'h9);
        repeat (7) tick();
        rd(14'h42, 32'h1, "one_tval1");
        tick();
        rd(14'h42, 32'h0, "one_tval0");
        rd(14'h5, 32'h800, "one_is11");
        wr(14'h44, 32'h1, 32'h1);
        repeat (10) tick();
        rd(14'h42, 32'h0, "one_stay0");
        rd(14'h5, 32'h0, "one_no_refire");

        do_reset();
        wr(14'h41, 32'hFFFF_FFFF, 32'h9);
        repeat (5) tick();
        rd(14'h42, 32'h3, "mid_tval3");
        #2;
        resetn = 0;
        rd(14'h42, 32'h0, "mid_rst_tval");
        rd(14'h41, 32'h0, "mid_rst_tcfg");
        resetn = 1;
        tick();
`else
        do_reset();
        wr(14'h41, 32'hFFFF_FFFF, 32'hB);
        wr(14'h40, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wr(14'h44, 32'h1, 32'h1);
        repeat (20) tick();
        rd(14'h40, 32'h0, "notimer_tid");
        rd(14'h41, 32'h0, "notimer_tcfg");
        rd(14'h42, 32'h0, "notimer_tval");
        rd(14'h5, 32'h0, "notimer_estat");
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
